// File: rtl/lsio_btn_ctrl.sv
// lsio_btn_ctrl: front end for an array of NUM_BTN button trackers.
//   - Generates the shared 1 ms tick.
//   - Synchronises and debounces the raw pad inputs for the trackers.
//   - Runs a read-and-clear handshake so software sees each tracker's status atomically.
//   - Merges the trackers' long-press reset requests into one stretched reset pulse.
//
// Ports:
//   clk_i, rst_i       clock, asynchronous active-high reset
//   btn_raw_i          raw pad levels (asynchronous to clk_i)
//   one_ms_event_o     one-cycle 1 ms tick, shared with the trackers
//   btn_o              debounced levels, frozen per button during a read of that button
//   status_i           tracker status, button k at [6k+5:6k] = {was_pressed, longest_press}
//   clear_o            one-cycle clear strobe per tracker
//   reset_req_i        sticky tracker reset requests
//   rd_req_i/rd_idx_i  read request and button index, taken while rd_ready_o=1
//   rd_ready_o         read FSM idle
//   rd_valid_o         one-cycle response strobe
//   rd_data_o          captured status of the requested button
//   sys_rst_o          stretched system reset request
module lsio_btn_ctrl #(
    parameter int unsigned NUM_BTN      = 4,
    parameter int unsigned TICKS_PER_MS = 50000,
    parameter int unsigned DEBOUNCE_MS  = 8,
    parameter int unsigned RST_PULSE_MS = 16,
    localparam int unsigned IDX_W       = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_BTN-1:0]     btn_raw_i,
    output logic                   one_ms_event_o,
    output logic [NUM_BTN-1:0]     btn_o,
    input  logic [6*NUM_BTN-1:0]   status_i,
    output logic [NUM_BTN-1:0]     clear_o,
    input  logic [NUM_BTN-1:0]     reset_req_i,
    input  logic                   rd_req_i,
    input  logic [IDX_W-1:0]       rd_idx_i,
    output logic                   rd_ready_o,
    output logic                   rd_valid_o,
    output logic [5:0]             rd_data_o,
    output logic                   sys_rst_o
);

    localparam int unsigned TICK_W  = $clog2(TICKS_PER_MS);
    localparam int unsigned DB_W    = $clog2(DEBOUNCE_MS + 1);
    localparam int unsigned PULSE_W = $clog2(RST_PULSE_MS + 1);

    localparam logic [TICK_W-1:0]  TickLast  = TICK_W'(TICKS_PER_MS - 1);
    localparam logic [TICK_W-1:0]  TickPre   = TICK_W'(TICKS_PER_MS - 2);
    localparam logic [DB_W-1:0]    DbLast    = DB_W'(DEBOUNCE_MS - 1);
    localparam logic [PULSE_W-1:0] PulseLoad = PULSE_W'(RST_PULSE_MS);

    // ------------------------------------------------------------------
    // 1 ms tick
    // ------------------------------------------------------------------
    logic [TICK_W-1:0] tick_cnt_q;
    logic              tick_q;

    // tick_q is registered but still coincides with tick_cnt_q == TickLast.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tick_cnt_q <= '0;
            tick_q     <= 1'b0;
        end else begin
            tick_cnt_q <= (tick_cnt_q == TickLast) ? '0 : tick_cnt_q + 1'b1;
            tick_q     <= (tick_cnt_q == TickPre);
        end
    end

    assign one_ms_event_o = tick_q;

    // ------------------------------------------------------------------
    // Synchroniser and debouncer
    // ------------------------------------------------------------------
    logic [NUM_BTN-1:0] sync1_q, sync2_q, db_state_q;
    logic [DB_W-1:0]    db_cnt_q [NUM_BTN];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            db_state_q <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= btn_raw_i;
            sync2_q <= sync1_q;
            if (tick_q) begin
                for (int i = 0; i < NUM_BTN; i++) begin
                    if (sync2_q[i] != db_state_q[i]) begin
                        if (db_cnt_q[i] == DbLast) begin
                            db_state_q[i] <= ~db_state_q[i];
                            db_cnt_q[i]   <= '0;
                        end else begin
                            db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
                        end
                    end else begin
                        db_cnt_q[i] <= '0;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read-and-clear FSM
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {StIdle, StWait, StCapture, StClear, StResp} rd_state_e;

    rd_state_e          rd_state_q;
    logic [IDX_W-1:0]   rd_idx_q;
    logic               rd_ready_q, rd_valid_q;
    logic [NUM_BTN-1:0] clear_q;
    logic [5:0]         rd_data_q;

    logic [5:0]         cap_data;
    logic [NUM_BTN-1:0] clr_sel;
    logic [NUM_BTN-1:0] hold;

    // An index that matches no button selects nothing: reads 0, clears nothing.
    // hold keeps btn_o[idx] at its accept-cycle value from the accept edge up to,
    // but not including, the RESP edge, which reloads the live debounced state.
    always_comb begin
        cap_data = '0;
        clr_sel  = '0;
        hold     = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (rd_idx_q == IDX_W'(i)) begin
                cap_data   = status_i[6*i +: 6];
                clr_sel[i] = 1'b1;
            end
            hold[i] = ((rd_state_q == StIdle) && rd_req_i && (rd_idx_i == IDX_W'(i))) ||
                      ((rd_state_q inside {StWait, StCapture, StClear}) &&
                       (rd_idx_q == IDX_W'(i)));
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_state_q <= StIdle;
            rd_idx_q   <= '0;
            rd_ready_q <= 1'b1;
            rd_valid_q <= 1'b0;
            clear_q    <= '0;
            rd_data_q  <= '0;
        end else begin
            unique case (rd_state_q)
                StIdle: begin
                    if (rd_req_i) begin
                        rd_idx_q   <= rd_idx_i;
                        rd_ready_q <= 1'b0;
                        rd_state_q <= StWait;
                    end
                end
                // Lets a tracker commit that is already in flight land in status_i.
                StWait: begin
                    rd_state_q <= StCapture;
                end
                StCapture: begin
                    rd_data_q  <= cap_data;
                    clear_q    <= clr_sel;
                    rd_state_q <= StClear;
                end
                StClear: begin
                    clear_q    <= '0;
                    rd_valid_q <= 1'b1;
                    rd_state_q <= StResp;
                end
                StResp: begin
                    rd_valid_q <= 1'b0;
                    rd_ready_q <= 1'b1;
                    rd_state_q <= StIdle;
                end
                default: begin
                    rd_state_q <= StIdle;
                end
            endcase
        end
    end

    logic [NUM_BTN-1:0] btn_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            btn_q <= '0;
        end else begin
            btn_q <= (btn_q & hold) | (db_state_q & ~hold);
        end
    end

    assign btn_o      = btn_q;
    assign clear_o    = clear_q;
    assign rd_ready_o = rd_ready_q;
    assign rd_valid_o = rd_valid_q;
    assign rd_data_o  = rd_data_q;

    // ------------------------------------------------------------------
    // Reset request arbiter
    // ------------------------------------------------------------------
    logic               armed_q, sys_rst_q;
    logic [PULSE_W-1:0] pulse_cnt_q;

    // Re-arming waits for the pulse to finish as well as for all requests to drop,
    // so only one pulse is ever in progress.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            armed_q     <= 1'b1;
            sys_rst_q   <= 1'b0;
            pulse_cnt_q <= '0;
        end else if (armed_q && (|reset_req_i)) begin
            armed_q     <= 1'b0;
            sys_rst_q   <= 1'b1;
            pulse_cnt_q <= PulseLoad;
        end else begin
            if (sys_rst_q && tick_q) begin
                pulse_cnt_q <= pulse_cnt_q - 1'b1;
                if (pulse_cnt_q == PULSE_W'(1)) begin
                    sys_rst_q <= 1'b0;
                end
            end
            if (!armed_q && !sys_rst_q && (reset_req_i == '0)) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign sys_rst_o = sys_rst_q;

endmodule

// File: tb/tb_lsio_btn_ctrl.sv
module tb_lsio_btn_ctrl;

    localparam int N = 2;
    localparam int T = 4;
    localparam int D = 2;
    localparam int P = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  btn_raw = '0;
    logic [6*N-1:0] status = '0;
    logic [N-1:0]  reset_req = '0;
    logic          rd_req = 1'b0;
    logic          rd_idx = 1'b0;

    logic          one_ms_event;
    logic [N-1:0]  btn;
    logic [N-1:0]  clear;
    logic          rd_ready, rd_valid, sys_rst;
    logic [5:0]    rd_data;

    lsio_btn_ctrl #(
        .NUM_BTN      (N),
        .TICKS_PER_MS (T),
        .DEBOUNCE_MS  (D),
        .RST_PULSE_MS (P)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .btn_raw_i      (btn_raw),
        .one_ms_event_o (one_ms_event),
        .btn_o          (btn),
        .status_i       (status),
        .clear_o        (clear),
        .reset_req_i    (reset_req),
        .rd_req_i       (rd_req),
        .rd_idx_i       (rd_idx),
        .rd_ready_o     (rd_ready),
        .rd_valid_o     (rd_valid),
        .rd_data_o      (rd_data),
        .sys_rst_o      (sys_rst)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: edges since release, sync history, debounced level and run
    // length, read phase (0 idle, 1..4 cycles since accept), remaining pulse ticks.
    int         m_n;
    int         m_h1 [N];
    int         m_h2 [N];
    int         m_state [N];
    int         m_cnt [N];
    int         m_btn [N];
    int         m_phase;
    int         m_idx;
    logic [5:0] m_data;
    int         m_armed;
    int         m_left;

    function automatic bit m_tick();
        return (m_n % T) == (T - 1);
    endfunction

    task automatic model_reset();
        m_n = 0;
        for (int i = 0; i < N; i++) begin
            m_h1[i] = 0; m_h2[i] = 0; m_state[i] = 0; m_cnt[i] = 0; m_btn[i] = 0;
        end
        m_phase = 0;
        m_idx   = 0;
        m_data  = '0;
        m_armed = 1;
        m_left  = 0;
    endtask

    // Advance the model across one clock edge using the inputs currently applied.
    task automatic model_edge();
        bit tk;
        int was_left;
        tk = m_tick();
        for (int i = 0; i < N; i++) begin
            bit frozen;
            frozen = (m_phase == 0 && rd_req && int'(rd_idx) == i) ||
                     (m_phase >= 1 && m_phase <= 3 && m_idx == i);
            if (!frozen) m_btn[i] = m_state[i];
        end
        if (tk) begin
            for (int i = 0; i < N; i++) begin
                if (m_h2[i] != m_state[i]) begin
                    m_cnt[i]++;
                    if (m_cnt[i] == D) begin
                        m_state[i] = 1 - m_state[i];
                        m_cnt[i]   = 0;
                    end
                end else begin
                    m_cnt[i] = 0;
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            m_h2[i] = m_h1[i];
            m_h1[i] = int'(btn_raw[i]);
        end
        if (m_phase == 2) m_data = status[6*m_idx +: 6];
        if (m_phase == 0) begin
            if (rd_req) begin
                m_idx   = int'(rd_idx);
                m_phase = 1;
            end
        end else begin
            m_phase = (m_phase + 1) % 5;
        end
        if (m_armed != 0 && reset_req != '0) begin
            m_left  = P;
            m_armed = 0;
        end else begin
            was_left = m_left;
            if (m_left > 0 && tk) m_left--;
            if (m_armed == 0 && was_left == 0 && reset_req == '0) m_armed = 1;
        end
        m_n++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [N-1:0] eb;
        logic [N-1:0] ec;
        for (int i = 0; i < N; i++) eb[i] = (m_btn[i] != 0);
        ec = '0;
        if (m_phase == 3) ec[m_idx] = 1'b1;
        check({tag, ".tick"},  32'(one_ms_event), 32'(m_tick()));
        check({tag, ".btn"},   32'(btn),          32'(eb));
        check({tag, ".clear"}, 32'(clear),        32'(ec));
        check({tag, ".ready"}, 32'(rd_ready),     32'(m_phase == 0));
        check({tag, ".valid"}, 32'(rd_valid),     32'(m_phase == 4));
        check({tag, ".data"},  32'(rd_data),      32'(m_data));
        check({tag, ".sysrst"}, 32'(sys_rst),     32'(m_left > 0));
    endtask

    task automatic cyc(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        int ticks_seen;
        int tick_hi;
        int rises;
        logic prev_sys;
        logic prev_b1;

        // 1: reset state and tick cadence
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;
        ticks_seen = 0;
        for (int c = 0; c < 12; c++) begin
            cyc("tick");
            if (one_ms_event) ticks_seen++;
        end
        check("tick_count", 32'(ticks_seen), 32'd3);

        // 2: held press on button 0, one-tick glitch on button 1
        btn_raw[0] = 1'b1;
        btn_raw[1] = 1'b1;
        for (int c = 0; c < T; c++) cyc("glitch");
        btn_raw[1] = 1'b0;
        for (int c = 0; c < 20; c++) cyc("press");
        check("press_btn0", 32'(btn[0]), 32'd1);
        check("glitch_btn1", 32'(btn[1]), 32'd0);

        // 3: single read of button 0
        status = 12'h025;
        rd_req = 1'b1;
        rd_idx = 1'b0;
        cyc("rd0");
        rd_req = 1'b0;
        for (int c = 0; c < 3; c++) cyc("rd0");
        check("rd0_valid", 32'(rd_valid), 32'd1);
        check("rd0_data", 32'(rd_data), 32'h25);
        cyc("rd0");

        // 4: release of button 1 while it is repeatedly read
        btn_raw[1] = 1'b1;
        for (int c = 0; c < 24; c++) cyc("b1on");
        check("b1_high", 32'(btn[1]), 32'd1);
        btn_raw[1] = 1'b0;
        rd_req = 1'b1;
        rd_idx = 1'b1;
        prev_b1 = btn[1];
        for (int c = 0; c < 30; c++) begin
            status = 12'($urandom);
            cyc("frz");
            if (clear[1]) check("clr_no_edge", 32'(btn[1]), 32'(prev_b1));
            prev_b1 = btn[1];
        end
        rd_req = 1'b0;
        for (int c = 0; c < 6; c++) cyc("frz_tail");
        check("b1_low", 32'(btn[1]), 32'd0);

        // 5: held simultaneous requests give one pulse; re-arm after drop
        reset_req = 2'b11;
        tick_hi = 0; rises = 0; prev_sys = sys_rst;
        for (int c = 0; c < 40; c++) begin
            cyc("arb");
            if (sys_rst && one_ms_event) tick_hi++;
            if (sys_rst && !prev_sys) rises++;
            prev_sys = sys_rst;
        end
        check("arb_ticks", 32'(tick_hi), 32'd3);
        check("arb_rises", 32'(rises), 32'd1);
        reset_req = 2'b00;
        for (int c = 0; c < 5; c++) cyc("arb_drop");
        reset_req = 2'b01;
        tick_hi = 0; rises = 0; prev_sys = sys_rst;
        for (int c = 0; c < 20; c++) begin
            cyc("arb2");
            if (sys_rst && one_ms_event) tick_hi++;
            if (sys_rst && !prev_sys) rises++;
            prev_sys = sys_rst;
        end
        check("arb2_ticks", 32'(tick_hi), 32'd3);
        check("arb2_rises", 32'(rises), 32'd1);
        reset_req = 2'b00;
        for (int c = 0; c < 20; c++) cyc("arb_idle");

        // Randomised traffic
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(7) == 0) btn_raw[$urandom_range(N - 1)] ^= 1'b1;
            status = 12'($urandom);
            rd_req = ($urandom_range(2) == 0);
            rd_idx = 1'($urandom);
            if ($urandom_range(39) == 0) reset_req = 2'($urandom);
            cyc("rand");
        end

        // 6: asynchronous reset during CAPTURE with a pulse in progress
        rd_req = 1'b0;
        reset_req = 2'b00;
        for (int c = 0; c < 20; c++) cyc("pre_rst");
        reset_req = 2'b10;
        rd_req = 1'b1;
        rd_idx = 1'b1;
        cyc("mid");
        rd_req = 1'b0;
        cyc("mid");
        check("mid_sysrst", 32'(sys_rst), 32'd1);
        check("mid_ready", 32'(rd_ready), 32'd0);
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        repeat (2) @(posedge clk);
        #1;
        check_all("hold_rst");
        rst = 1'b0;
        for (int c = 0; c < 30; c++) cyc("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lsio_btn_ctrl.md
Name: lsio_btn_ctrl

Overview:
Front-end controller for an array of NUM_BTN button trackers in the LSIO block. It does four jobs:
- generates the shared 1 ms tick;
- synchronises and debounces the raw pad inputs that feed the trackers;
- runs a read-and-clear handshake so software reads each tracker's status atomically;
- arbitrates the trackers' long-press reset requests into one stretched system reset pulse.

Parameters:
NUM_BTN, 4, number of buttons/trackers (>=1)
TICKS_PER_MS, 50000, clk_i cycles per 1 ms tick (>=2)
DEBOUNCE_MS, 8, consecutive ticks a new level must be stable before btn_o changes (>=1)
RST_PULSE_MS, 16, ticks sys_rst_o is held high (>=1)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous, active-high reset
btn_raw_i  in  NUM_BTN  raw pad levels, asynchronous to clk_i
one_ms_event_o  out  1  one-cycle tick, also fed to every tracker
btn_o  out  NUM_BTN  debounced (and possibly frozen) levels, one to each tracker
status_i  in  6*NUM_BTN  tracker status; button k at [6k+5:6k] = {was_pressed, longest_press[4:0]}
clear_o  out  NUM_BTN  one-cycle clear strobe per tracker
reset_req_i  in  NUM_BTN  tracker reset requests; sticky levels
rd_req_i  in  1  read request, accepted when rd_ready_o=1
rd_idx_i  in  max(1,$clog2(NUM_BTN))  button to read
rd_ready_o  out  1  controller idle
rd_valid_o  out  1  one-cycle response strobe
rd_data_o  out  6  captured status of the requested button
sys_rst_o  out  1  stretched system reset request

Behaviour:
Reset (rst_i high, asynchronous): all outputs are 0, except rd_ready_o=1. All counters, sync flops and the FSM clear. State is IDLE. The reset arbiter is armed.

Tick:
- Counter runs 0..TICKS_PER_MS-1 and wraps to 0.
- one_ms_event_o=1 for exactly the cycle the counter equals TICKS_PER_MS-1.
- First tick occurs TICKS_PER_MS cycles after reset release.

Debounce, per button:
- 2-flop synchroniser, then compare against the debounced state.
- On a tick where synced != state, increment a counter; on a tick where synced == state, zero the counter.
- When the counter reaches DEBOUNCE_MS, toggle state and zero the counter.
- Glitches shorter than DEBOUNCE_MS ticks never propagate.
- btn_o is registered.

Read FSM, states IDLE, WAIT, CAPTURE, CLEAR, RESP:
- IDLE: rd_ready_o=1. If rd_req_i, latch rd_idx_i, freeze btn_o[idx] at its current value, go to WAIT. An out-of-range index latches but reads 0 and issues no clear.
- WAIT: one cycle, so any tracker release commit in flight becomes visible.
- CAPTURE: rd_data_o <= status_i[idx].
- CLEAR: clear_o[idx]=1 for this cycle only.
- RESP: rd_valid_o=1 for one cycle; unfreeze, with btn_o[idx] taking the live debounced state next cycle; return to IDLE.
- Latency is request cycle +4 to rd_valid_o. rd_data_o holds its value until the next CAPTURE.
- rd_req_i is ignored while not IDLE, with no queuing. Back-to-back reads are possible: a new request is accepted in the IDLE cycle after RESP.
- While frozen, the debouncer keeps running underneath. A change that completes during the freeze appears on unfreeze.

Reset arbiter:
- Armed and any reset_req_i bit high: set sys_rst_o=1, load the pulse counter, disarm.
- Decrement on each tick. After RST_PULSE_MS ticks, drop sys_rst_o.
- Re-arm only once reset_req_i is all zero. A continuously held request therefore produces exactly one pulse.
- Simultaneous requests from several buttons give one pulse.
- Read FSM and arbiter are independent; both may act in the same cycle.

Test Plan (NUM_BTN=2, TICKS_PER_MS=4, DEBOUNCE_MS=2, RST_PULSE_MS=3):
1. Release rst_i -> one_ms_event_o high on cycles 4, 8, 12 and low elsewhere; all other outputs 0; rd_ready_o=1.
2. btn_raw_i[0]=1 held -> btn_o[0] rises after the 2nd tick following sync. A 1-tick pulse on btn_raw_i[1] -> btn_o[1] stays 0.
3. status_i[5:0]=6'b1_00101, rd_req_i with idx 0 at cycle t -> clear_o[0] high at t+3 only; rd_valid_o high at t+4 with rd_data_o=6'h25; rd_ready_o low t+1..t+4.
4. btn_o[1]=1; read idx 1 while btn_raw_i[1] falls -> btn_o[1] stays 1 through RESP and falls after unfreeze; clear_o[1] is never concurrent with a btn_o[1] edge.
5. reset_req_i=2'b11 held -> sys_rst_o high for exactly 3 ticks, then no second pulse. Drop to 0, then set bit 0 -> new 3-tick pulse.
6. Assert rst_i mid-read (in CAPTURE) and mid-pulse -> FSM returns to IDLE, freeze released, sys_rst_o=0 immediately, clear_o never pulses.
